// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants and Gray/binary conversion helpers
package fifo_pkg;

    localparam int SYNC_STAGES = 2;

    // 32-bit helpers: callers zero-extend narrower pointers and truncate the result
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray_sync.sv
// rtl/fifo_gray_sync.sv - multi-flop synchronizer for a Gray-coded pointer
module fifo_gray_sync
    import fifo_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [width-1:0] async_value,
    output logic [width-1:0] sync_value
);

    logic [width-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= async_value;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign sync_value = stage[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_read_controller.sv
// rtl/fifo_read_controller.sv - async FIFO read-side pointer, empty and data-valid logic
// Optional almost-empty flag compiled in with FIFO_ALMOST_EMPTY_EN.
module fifo_read_controller
    import fifo_pkg::*;
#(
    parameter int depth        = 8,
    parameter int almost_level = 2
) (
    input  logic             rd_clock,
    input  logic             reset_n,
    input  logic [depth-1:0] wr_gray,
    input  logic             enable,
    output logic [depth-2:0] rd_address,
    output logic [depth-1:0] gray_value,
    output logic             empty,
    output logic             data_valid
`ifdef FIFO_ALMOST_EMPTY_EN
    ,
    output logic             almost_empty
`endif
);

    logic [depth-1:0] wsync2;
    logic [depth-1:0] rd_bin;
    logic [depth-1:0] rd_bin_next;
    logic [depth-1:0] gray_next;
    logic             accept;

    fifo_gray_sync #(
        .width(depth)
    ) u_wr_sync (
        .clock      (rd_clock),
        .reset_n    (reset_n),
        .async_value(wr_gray),
        .sync_value (wsync2)
    );

    assign accept      = enable & ~empty;
    assign rd_bin_next = rd_bin + depth'(accept);
    assign gray_next   = depth'(bin2gray(32'(rd_bin_next)));
    assign rd_address  = rd_bin[depth-2:0];

    // Empty looks ahead at the next pointer so reading the last entry flags it on that edge
    always_ff @(posedge rd_clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_bin     <= '0;
            gray_value <= '0;
            empty      <= 1'b1;
            data_valid <= 1'b0;
        end else begin
            rd_bin     <= rd_bin_next;
            gray_value <= gray_next;
            empty      <= (gray_next == wsync2);
            data_valid <= accept;
        end
    end

`ifdef FIFO_ALMOST_EMPTY_EN
    logic [depth-1:0] wr_bin_sync;
    logic [depth-1:0] level;

    assign wr_bin_sync = depth'(gray2bin(32'(wsync2)));
    assign level       = wr_bin_sync - rd_bin_next;

    always_ff @(posedge rd_clock or negedge reset_n) begin
        if (!reset_n) begin
            almost_empty <= 1'b1;
        end else begin
            almost_empty <= (level <= depth'(almost_level));
        end
    end
`endif

endmodule

// File: tb/tb_fifo_read_controller.sv
// tb/tb_fifo_read_controller.sv - self-checking bench for fifo_read_controller (depth=4)
module tb_fifo_read_controller;

    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [D-1:0] wr_bin = '0;
    logic [D-1:0] wr_gray;
    logic [D-2:0] addr;
    logic [D-1:0] gv;
    logic         empty;
    logic         dv;
`ifdef FIFO_ALMOST_EMPTY_EN
    logic         ae;
`endif

    int n_checks = 0;
    int n_fail = 0;

    logic [D-1:0] m_rd, m_ws1, m_ws2;
    logic         m_empty, m_dv, m_ae;
    logic [D-2:0] sb [$];
    logic [D-2:0] prev_addr;
    int           dv_count;
    int           reads;

    typedef struct {
        logic [D-1:0] wr;
        logic         en;
        logic [D-2:0] addr;
        logic [D-1:0] gray;
        logic         empty;
        logic         dv;
    } vec_t;
    vec_t tbl [15];

    function automatic logic [D-1:0] g4(input logic [D-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [D-1:0] b4(input logic [D-1:0] g);
        logic [D-1:0] b;
        b[D-1] = g[D-1];
        for (int i = D - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic vec_t mk(input int w, input int e, input int a, input int g, input int em, input int d);
        vec_t v;
        v.wr = D'(w); v.en = 1'(e); v.addr = (D-1)'(a); v.gray = D'(g); v.empty = 1'(em); v.dv = 1'(d);
        return v;
    endfunction

    assign wr_gray = g4(wr_bin);

    always #5 clk = ~clk;

    fifo_read_controller #(
        .depth       (D),
        .almost_level(2)
    ) dut (
        .rd_clock    (clk),
        .reset_n     (rst_n),
        .wr_gray     (wr_gray),
        .enable      (en),
        .rd_address  (addr),
        .gray_value  (gv),
        .empty       (empty),
        .data_valid  (dv)
`ifdef FIFO_ALMOST_EMPTY_EN
        ,
        .almost_empty(ae)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rd = '0; m_ws1 = '0; m_ws2 = '0;
        m_empty = 1'b1; m_dv = 1'b0; m_ae = 1'b1;
        sb.delete();
        prev_addr = '0;
    endtask

    // One clock: drive enable on the falling edge, advance the model on the rising edge, compare 1ns later
    task automatic cycle(input logic e);
        logic         acc;
        logic [D-1:0] rd_n, lvl;
        logic         new_empty, new_ae;
        @(negedge clk);
        en = e;
        @(posedge clk);
        acc       = e && !m_empty;
        rd_n      = m_rd + D'(acc);
        new_empty = (g4(rd_n) == m_ws2);
        lvl       = b4(m_ws2) - rd_n;
        new_ae    = (lvl <= D'(2));
        if (acc) begin
            sb.push_back(m_rd[D-2:0]);
            reads++;
        end
        m_ws2 = m_ws1; m_ws1 = wr_gray;
        m_rd = rd_n; m_empty = new_empty; m_dv = acc; m_ae = new_ae;
        #1;
        check("rd_address", 32'(addr), 32'(m_rd[D-2:0]));
        check("gray_value", 32'(gv), 32'(g4(m_rd)));
        check("empty", 32'(empty), 32'(m_empty));
        check("data_valid", 32'(dv), 32'(m_dv));
`ifdef FIFO_ALMOST_EMPTY_EN
        check("almost_empty", 32'(ae), 32'(m_ae));
`endif
        if (dv === 1'b1) begin
            dv_count++;
            if (sb.size() == 0) check("sb_underrun", 32'(1), 32'(0));
            else check("sb_read_addr", 32'(prev_addr), 32'(sb.pop_front()));
        end
        prev_addr = addr;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_bin = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        reads = 0;
        dv_count = 0;
        model_reset();
        do_reset();
        check("reset_empty", 32'(empty), 32'(1));
        check("reset_gray", 32'(gv), 32'(0));
        check("reset_dv", 32'(dv), 32'(0));
        check("reset_addr", 32'(addr), 32'(0));
`ifdef FIFO_ALMOST_EMPTY_EN
        check("reset_ae", 32'(ae), 32'(1));
`endif

        // Sync latency, last-entry empty, then underflow with enable held
        tbl[0]  = mk(1, 0, 0, 0, 1, 0);
        tbl[1]  = mk(1, 1, 0, 0, 1, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 1, 1, 1, 1);
        tbl[4]  = mk(1, 1, 1, 1, 1, 0);
        tbl[5]  = mk(3, 0, 1, 1, 1, 0);
        tbl[6]  = mk(3, 0, 1, 1, 1, 0);
        tbl[7]  = mk(3, 1, 1, 1, 0, 0);
        tbl[8]  = mk(3, 1, 2, 3, 0, 1);
        tbl[9]  = mk(3, 1, 3, 2, 1, 1);
        for (int i = 10; i < 15; i++) tbl[i] = mk(3, 1, 3, 2, 1, 0);
        for (int i = 0; i < 15; i++) begin
            wr_bin = tbl[i].wr;
            cycle(tbl[i].en);
            check($sformatf("tbl%0d_addr", i), 32'(addr), 32'(tbl[i].addr));
            check($sformatf("tbl%0d_gray", i), 32'(gv), 32'(tbl[i].gray));
            check($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].empty));
            check($sformatf("tbl%0d_dv", i), 32'(dv), 32'(tbl[i].dv));
        end

        // Random streaming across the pointer wrap
        reads = 0;
        for (int c = 0; c < 400 && reads < 24; c++) begin
            if (D'(wr_bin - m_rd) < D'(8) && $urandom_range(0, 1) == 1) wr_bin = wr_bin + 1'b1;
            cycle($urandom_range(0, 3) != 0);
        end
        check("wrap_reads_done", 32'(reads >= 24), 32'(1));
        repeat (12) cycle(1'b1);
        check("drained_empty", 32'(empty), 32'(1));

        // Back-to-back: eight entries made visible at once
        wr_bin = m_rd + D'(8);
        repeat (3) cycle(1'b0);
        dv_count = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1);
            check($sformatf("b2b_empty_%0d", i), 32'(empty), 32'(i == 7));
        end
        check("b2b_dv_count", 32'(dv_count), 32'(8));
        cycle(1'b1);
        check("b2b_dv_after", 32'(dv), 32'(0));

        // Reset in the middle of a read burst
        wr_bin = m_rd + D'(5);
        repeat (3) cycle(1'b0);
        repeat (2) cycle(1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_empty", 32'(empty), 32'(1));
        check("midrst_gray", 32'(gv), 32'(0));
        check("midrst_dv", 32'(dv), 32'(0));
        do_reset();
        en = 1'b1;
        cycle(1'b1);
        check("postrst_dv", 32'(dv), 32'(0));
        check("postrst_addr", 32'(addr), 32'(0));

`ifdef FIFO_ALMOST_EMPTY_EN
        do_reset();
        wr_bin = D'(5);
        repeat (3) cycle(1'b0);
        check("ae_level5", 32'(ae), 32'(0));
        repeat (3) cycle(1'b1);
        check("ae_level2", 32'(ae), 32'(1));
        check("ae_level2_empty", 32'(empty), 32'(0));
`endif

        cycle(1'b0);
        check("sb_leftover", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_read_controller.md
FIFO_READ_CONTROLLER -- requirements
Module: fifo_read_controller

Interface
REQ-001 SHALL have parameter depth, default 8, meaning pointer width in bits; FIFO holds 2^(depth-1) entries.
REQ-002 SHALL have parameter almost_level, default 2, meaning almost-empty threshold in entries (used only under FIFO_ALMOST_EMPTY_EN).
REQ-003 SHALL have port rd_clock  input  1  read-domain clock; the block uses this single clock.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port wr_gray  input  depth  Gray-coded write pointer, asynchronous to rd_clock.
REQ-006 SHALL have port enable  input  1  read request from consumer.
REQ-007 SHALL have port rd_address  output  depth-1  binary RAM read address.
REQ-008 SHALL have port gray_value  output  depth  registered Gray-coded read pointer for the write domain.
REQ-009 SHALL have port empty  output  1  registered empty flag.
REQ-010 SHALL have port data_valid  output  1  RAM read data valid, one cycle after an accepted read.
REQ-011 SHALL have port almost_empty  output  1  present only when FIFO_ALMOST_EMPTY_EN is defined.

Function
REQ-012 SHALL synchronize wr_gray through exactly two rd_clock flops (wsync1, wsync2) before any use.
REQ-013 SHALL hold a depth-bit binary read counter rd_bin; rd_address = rd_bin[depth-2:0].
REQ-014 SHALL accept a read when enable=1 and empty=0; accepted read increments rd_bin by 1 on that edge, wrapping modulo 2^depth.
REQ-015 SHALL ignore enable while empty=1: rd_bin, gray_value unchanged, data_valid=0 next cycle.
REQ-016 SHALL register gray_value = rd_bin_next ^ (rd_bin_next >> 1), updated on the same edge as rd_bin.
REQ-017 SHALL register empty = (Gray of rd_bin_next == wsync2) each edge, so an accepted read of the last entry asserts empty on the same edge.
REQ-018 SHALL deassert empty on the third rd_clock edge after wr_gray changes (wsync1, wsync2, empty register), no earlier.
REQ-019 SHALL register data_valid = enable & ~empty, i.e. one-cycle read latency matching a synchronous RAM.
REQ-020 SHALL never let rd_bin pass the synchronized write pointer, including at wrap-around of bit depth-1.

Reset
REQ-021 SHALL on reset_n=0 force, asynchronously: rd_bin=0, gray_value=0, wsync1=wsync2=0, empty=1, data_valid=0, almost_empty=1.
REQ-022 SHALL abort an in-flight read on reset mid-operation: data_valid=0 in the first cycle after release.
REQ-023 SHALL require one rd_clock edge after reset_n release before enable is honoured.

Configuration
REQ-024 SHALL compile the almost-empty feature in only when macro FIFO_ALMOST_EMPTY_EN is defined.
REQ-025 With FIFO_ALMOST_EMPTY_EN: convert wsync2 to binary, level = wr_bin_sync - rd_bin_next (modulo 2^depth), register almost_empty = (level <= almost_level).
REQ-026 Without FIFO_ALMOST_EMPTY_EN: no almost_empty port, no Gray-to-binary logic; all other behaviour identical.

Structure
REQ-027 SHALL take Gray/binary conversion functions and SYNC_STAGES=2 from shared package fifo_pkg.
REQ-028 SHALL instantiate one sub-module fifo_gray_sync (depth-wide two-flop synchronizer, async active-low reset).
REQ-029 SHALL contain no RAM; storage lives in the FIFO top level.

Verification
REQ-030 Reset: depth=4, reset_n low mid-read -> empty=1, gray_value=0, data_valid=0 immediately, rd_address=0 after release.
REQ-031 Sync latency: wr_gray 0000->0001 at t0 -> empty falls on third rd_clock edge after t0; enable then -> rd_address 0->1, data_valid=1 next cycle, empty=1.
REQ-032 Underflow: empty=1, enable held 5 cycles -> rd_address, gray_value unchanged, data_valid=0 throughout.
REQ-033 Wrap: depth=4, 16 writes/reads streamed -> rd_bin 1111->0000, gray_value 1000->0000, empty only when pointers equal.
REQ-034 Almost-empty (FIFO_ALMOST_EMPTY_EN, almost_level=2): wr_gray = Gray(5), rd_bin=0 -> almost_empty=0; after 3 reads -> almost_empty=1, empty=0.
REQ-035 Back-to-back: 8 entries available, enable held 8 cycles -> 8 consecutive data_valid pulses, empty asserts on the 8th accepting edge.
